pipe_skid_stage: RTL and testbench



---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_en_reg.sv | 25 ++
 rtl/pipe_skid_stage.sv | 115 +++++++++++
 tb/tb_pipe_skid_stage.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic skid pipeline stage.
package pipe_pkg;

  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_BUSY  = 2'd1,
    SK_FULL  = 2'd2
  } skid_state_t;

  // Occupancy implied by a state; an illegal encoding reads as empty.
  function automatic logic [1:0] state_count(input skid_state_t st);
    logic [1:0] n;
    case (st)
      SK_EMPTY: n = 2'd0;
      SK_BUSY:  n = 2'd1;
      SK_FULL:  n = 2'(SKID_DEPTH);
      default:  n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_en_reg.sv
// WIDTH-bit register with load enable, asynchronously reset to zero.
module pipe_en_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Payload storage: loads only when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid pipeline stage: registered upstream ready, head entry
// driven straight from the main register, flush discards everything.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  skid_state_t      r_state;
  skid_state_t      w_next_state;
  logic             r_in_ready;
  logic [1:0]       r_count;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_en;
  logic             w_skid_en;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  // Flush masks both handshakes in its own cycle.
  assign in_ready   = r_in_ready & ~flush;
  assign out_valid  = (r_state != SK_EMPTY) & ~flush;
  assign out_data   = w_main_q;
  assign count      = r_count;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // Next-state and register-load decode.
  always_comb begin
    w_next_state = r_state;
    w_main_en    = 1'b0;
    w_skid_en    = 1'b0;
    w_main_d     = in_data;
    if (flush) begin
      w_next_state = SK_EMPTY;
    end else begin
      case (r_state)
        SK_EMPTY: begin
          if (w_in_fire) begin
            w_next_state = SK_BUSY;
            w_main_en    = 1'b1;
          end else begin
            w_next_state = SK_EMPTY;
          end
        end
        SK_BUSY: begin
          if (w_in_fire && w_out_fire) begin
            w_main_en    = 1'b1;
          end else if (w_in_fire) begin
            w_next_state = SK_FULL;
            w_skid_en    = 1'b1;
          end else if (w_out_fire) begin
            w_next_state = SK_EMPTY;
          end else begin
            w_next_state = SK_BUSY;
          end
        end
        SK_FULL: begin
          if (w_out_fire) begin
            w_next_state = SK_BUSY;
            w_main_en    = 1'b1;
            w_main_d     = w_skid_q;
          end else begin
            w_next_state = SK_FULL;
          end
        end
        default: begin
          w_next_state = SK_EMPTY;
        end
      endcase
    end
  end

  // Control state, registered ready and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= SK_EMPTY;
      r_in_ready <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != SK_FULL);
      r_count    <= state_count(w_next_state);
    end
  end

  pipe_en_reg #(.WIDTH(WIDTH)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (w_main_en),
    .d   (w_main_d),
    .q   (w_main_q)
  );

  pipe_en_reg #(.WIDTH(WIDTH)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (w_skid_en),
    .d   (in_data),
    .q   (w_skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: per-cycle vector table plus
// hand-written reset sequences.
module tb_pipe_skid_stage;

  localparam int WIDTH = 32;

  logic             clk;
  logic             clk_run;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  int n_vec;
  int n_bad;

  typedef struct {
    logic             flush;
    logic             iv;
    logic [WIDTH-1:0] id;
    logic             ordy;
    logic             e_ov;
    logic [WIDTH-1:0] e_od;
    logic             e_ir;
    logic [1:0]       e_cnt;
  } vec_t;

  vec_t vecs[$];

  pipe_skid_stage #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = clk_run ? ~clk : clk;

  function automatic vec_t mk(logic fl, logic iv, logic [WIDTH-1:0] id, logic ordy,
                              logic e_ov, logic [WIDTH-1:0] e_od, logic e_ir,
                              logic [1:0] e_cnt);
    vec_t v;
    v.flush = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    clk_run = 1'b0;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset with the clock stopped.
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_count",     {30'd0, count},     32'd0);
    #2 rst = 1'b0;
    #1;
    chk("rel_in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    clk_run = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready_first_edge", {31'd0, in_ready}, 32'd1);

    // Streaming through, then stall-to-full, hold, drain, and flush.
    vecs.push_back(mk(1'b0, 1'b1, 32'h11, 1'b1, 1'b0, 32'h0,  1'b1, 2'd0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h22, 1'b1, 1'b1, 32'h11, 1'b1, 2'd1));
    vecs.push_back(mk(1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 32'h22, 1'b1, 2'd1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h33, 1'b1, 2'd1));
    vecs.push_back(mk(1'b0, 1'b1, 32'hA0, 1'b0, 1'b0, 32'h0,  1'b1, 2'd0));
    vecs.push_back(mk(1'b0, 1'b1, 32'hA1, 1'b0, 1'b1, 32'hA0, 1'b1, 2'd1));
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(1'b0, 1'b1, 32'hA2, 1'b0, 1'b1, 32'hA0, 1'b0, 2'd2));
    vecs.push_back(mk(1'b0, 1'b1, 32'hA2, 1'b1, 1'b1, 32'hA0, 1'b0, 2'd2));
    vecs.push_back(mk(1'b0, 1'b1, 32'hA2, 1'b1, 1'b1, 32'hA1, 1'b1, 2'd1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'hA2, 1'b1, 2'd1));
    vecs.push_back(mk(1'b0, 1'b1, 32'hB0, 1'b0, 1'b0, 32'h0,  1'b1, 2'd0));
    vecs.push_back(mk(1'b0, 1'b1, 32'hB1, 1'b0, 1'b1, 32'hB0, 1'b1, 2'd1));
    vecs.push_back(mk(1'b1, 1'b1, 32'hB2, 1'b1, 1'b0, 32'h0,  1'b0, 2'd2));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b1, 2'd0));
    vecs.push_back(mk(1'b0, 1'b1, 32'hC0, 1'b1, 1'b0, 32'h0,  1'b1, 2'd0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'hC0, 1'b1, 2'd1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  1'b1, 2'd0));

    foreach (vecs[i]) begin
      @(negedge clk);
      flush = vecs[i].flush; in_valid = vecs[i].iv;
      in_data = vecs[i].id;  out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
      chk($sformatf("v%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].e_ir});
      chk($sformatf("v%0d_count", i),     {30'd0, count},     {30'd0, vecs[i].e_cnt});
      if (vecs[i].e_ov)
        chk($sformatf("v%0d_out_data", i), out_data, vecs[i].e_od);
    end

    // Asynchronous reset while busy, then the first entry after release.
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b1; in_data = 32'h5A; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; #1;
    chk("busy_out_valid", {31'd0, out_valid}, 32'd1);
    chk("busy_out_data",  out_data, 32'h5A);
    #1 rst = 1'b1; #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_count",     {30'd0, count},     32'd0);
    chk("arst_in_ready",  {31'd0, in_ready},  32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b1; #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0; #1;
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_out_data",  out_data, 32'h77);
    chk("post_rst_count",     {30'd0, count}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
